// File: rtl/scoreboard_ctrl.sv
// Issue-stage scoreboard: per-register, hi/lo and divider latency countdowns, stall generation.
// Combinational stall/accept; counters update one edge after issue. Define SCOREBOARD_FWD_EN for bypass-aware RAW rule.
// Backpressure: stall holds the issue stage until RAW, WAW and divider hazards clear.
module scoreboard_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int LAT_W    = 6,
    localparam int IW      = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [IW-1:0]       rs,
    input  logic [IW-1:0]       rt,
    input  logic                rf_rena1,
    input  logic                rf_rena2,
    input  logic                rf_wena,
    input  logic [IW-1:0]       rd,
    input  logic [LAT_W-1:0]    issue_lat,
    input  logic                hilo_wena,
    input  logic                hilo_rena,
    input  logic                div_start,
    input  logic                flush,
    output logic                stall,
    output logic                issue_accept,
    output logic [NUM_REGS-1:0] reg_busy,
    output logic                hilo_busy,
    output logic                div_busy
);

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] hilo_cnt;
    logic [LAT_W-1:0] div_cnt;

    logic raw_haz;
    logic waw_haz;
    logic struct_haz;
    logic load_rd;

    // With forwarding, a producer in its final cycle is bypassed and does not block readers.
    function automatic logic hazard(input logic [LAT_W-1:0] c);
`ifdef SCOREBOARD_FWD_EN
        return c > LAT_W'(1);
`else
        return c != '0;
`endif
    endfunction

    always_comb begin
        raw_haz    = (rf_rena1 && hazard(cnt[rs]))
                   || (rf_rena2 && hazard(cnt[rt]))
                   || (hilo_rena && hazard(hilo_cnt));
        waw_haz    = (rf_wena && (rd != '0) && (cnt[rd] > LAT_W'(1)))
                   || (hilo_wena && (hilo_cnt > LAT_W'(1)));
        struct_haz = div_start && (div_cnt != '0);
    end

    assign stall        = issue_valid && (raw_haz || waw_haz || struct_haz);
    assign issue_accept = issue_valid && !stall && !flush;
    assign load_rd      = issue_accept && rf_wena && (rd != '0) && (issue_lat != '0);

    always_comb begin
        reg_busy = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            reg_busy[i] = cnt[i] != '0;
        end
    end

    assign hilo_busy = hilo_cnt != '0;
    assign div_busy  = div_cnt != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
            hilo_cnt <= '0;
            div_cnt  <= '0;
        end else begin
            cnt[0] <= '0;
            // A load on a register with count 1 replaces the final decrement in the same edge.
            for (int i = 1; i < NUM_REGS; i++) begin
                if (load_rd && (rd == IW'(i))) begin
                    cnt[i] <= issue_lat;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - LAT_W'(1);
                end
            end

            if (issue_accept && hilo_wena) begin
                hilo_cnt <= issue_lat;
            end else if (hilo_cnt != '0) begin
                hilo_cnt <= hilo_cnt - LAT_W'(1);
            end

            if (issue_accept && div_start) begin
                div_cnt <= issue_lat;
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - LAT_W'(1);
            end
        end
    end

endmodule

// File: doc/scoreboard_ctrl.md
SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 32, is the number of architectural registers tracked; register index width is clog2(NUM_REGS).
REQ-002 Parameter LAT_W, default 6, is the width of each latency countdown counter.
REQ-003 clk  input  1  is the system clock; all state updates on the rising edge.
REQ-004 rst  input  1  is an asynchronous, active-high reset.
REQ-005 issue_valid  input  1  means an instruction is presented for issue this cycle.
REQ-006 rs / rt  input  clog2(NUM_REGS) each  are the source register indices.
REQ-007 rf_rena1 / rf_rena2  input  1 each  qualify the rs and rt reads.
REQ-008 rf_wena  input  1  means the issuing instruction writes rd.
REQ-009 rd  input  clog2(NUM_REGS)  is the destination register index.
REQ-010 issue_lat  input  LAT_W  is the cycles until rd's result is written back; 0 means untracked.
REQ-011 hilo_wena  input  1  means the instruction writes hi/lo (mul/div/mthi/mtlo).
REQ-012 hilo_rena  input  1  means the instruction reads hi/lo (mfhi/mflo).
REQ-013 div_start  input  1  means the instruction occupies the iterative divider.
REQ-014 flush  input  1  means the presented instruction is squashed (exception/eret).
REQ-015 stall  output  1  holds the issue stage, combinational.
REQ-016 issue_accept  output  1  is issue_valid & ~stall & ~flush.
REQ-017 reg_busy  output  NUM_REGS  gives per-register pending-write status (counter != 0).
REQ-018 hilo_busy  output  1  gives hi/lo pending-write status.
REQ-019 div_busy  output  1  means the divider is occupied.

Function
REQ-020 One LAT_W counter SHALL exist per register, plus a hilo counter and a div counter.
REQ-021 Every nonzero counter SHALL decrement by 1 each cycle; a zero counter SHALL hold at 0.
REQ-022 On issue_accept with rf_wena, rd != 0 and issue_lat != 0, counter[rd] SHALL load issue_lat on that edge, with load taking priority over decrement.
REQ-023 Register 0 SHALL never become busy; reg_busy[0] SHALL be 0 always.
REQ-024 On issue_accept with hilo_wena, the hilo counter SHALL load issue_lat; on issue_accept with div_start, the div counter SHALL load issue_lat.
REQ-025 RAW stall SHALL assert when issue_valid and (rf_rena1 & hazard(rs)) or (rf_rena2 & hazard(rt)) or (hilo_rena & hazard(hilo)).
REQ-026 WAW stall SHALL assert when issue_valid & rf_wena & rd != 0 & counter[rd] > 1, or issue_valid & hilo_wena & hilo counter > 1.
REQ-027 Counter == 1 SHALL NOT cause WAW stall; a new issue reloads it in the same cycle.
REQ-028 Structural stall SHALL assert when issue_valid & div_start & div counter != 0.
REQ-029 Flush SHALL suppress issue_accept, so no counter loads that cycle, while in-flight counters SHALL continue to decrement unaffected.
REQ-030 stall SHALL be 0 whenever issue_valid is 0.
REQ-031 Counter arithmetic SHALL be unsigned, with no wrap below 0.

Reset
REQ-032 While rst is high, all counters SHALL be 0, so reg_busy = 0, hilo_busy = 0 and div_busy = 0, independent of clk.
REQ-033 Reset asserted mid-operation SHALL discard all pending entries immediately.
REQ-034 The first accepted issue SHALL occur on the first rising edge after rst falls.

Configuration
REQ-035 Macro SCOREBOARD_FWD_EN selects the RAW hazard rule.
REQ-036 With SCOREBOARD_FWD_EN defined, hazard(x) SHALL be counter[x] > 1, because the final-cycle result is bypassed.
REQ-037 Without SCOREBOARD_FWD_EN, hazard(x) SHALL be counter[x] != 0.

Verification
REQ-038 Reset check: assert rst asynchronously mid-cycle with counter[5] = 3 -> reg_busy = 0 immediately, before any clk edge.
REQ-039 RAW with FWD_EN: issue rd = 5, lat = 3, then next cycle rs = 5 with rf_rena1 -> stall high for 1 cycle (counter 2), low when counter = 1.
REQ-040 RAW without FWD_EN: same stimulus as REQ-039 -> stall high for 2 cycles.
REQ-041 Register 0 and flush: issue rd = 0, lat = 4 -> reg_busy stays 0; issue rd = 7 with flush = 1 -> issue_accept = 0 and reg_busy[7] stays 0.
REQ-042 Divider structural hazard: div_start with lat = 33, then div_start again -> stall for 32 cycles; a mfhi at cycle 10 stalls until the hilo counter reaches the hazard threshold.
REQ-043 WAW reload: rd = 9, lat = 2, then rd = 9, lat = 5 next cycle (counter = 1) -> no stall, and counter[9] = 5.
